memory_dreq_issue: RTL and testbench
====================================

# memory_dreq_issue

Memory-stage data-bus request controller for the MIPS pipeline. It takes the load/store described by the memory stage, checks alignment, builds the aligned `dbus_req_t` (address, size, byte strobe, shifted store data), runs the valid/addr_ok/data_ok handshake, and holds the pipeline until the access completes. It returns the raw response word, which the downstream dresp-data select logic aligns and sign-extends for loads, including LWL/LWR merging.

## Interface
Parameters: none. Widths come from shared types (`word_t` = 32 bits).

- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `in_valid` in 1: memory stage holds a load/store; stable while `stall`=1.
- `in_is_store` in 1: 1 = store, 0 = load.
- `in_op` in `op_t`: distinguishes LWL/LWR/SWL/SWR from plain accesses.
- `in_args` in `memory_args_t`: `addr`, `msize` (MSIZE1/2/4), `sig`.
- `in_store_data` in 32: rt value for stores.
- `flush` in 1: squash the current memory-stage instruction.
- `advance` in 1: the memory stage hands its result to the next stage this cycle.
- `dreq` out `dbus_req_t`: {valid, addr, size, strobe, data}.
- `dresp` in `dbus_resp_t`: {addr_ok, data_ok, data}.
- `stall` out 1: the memory stage must hold.
- `raw_valid` out 1: `raw_data` holds the completed response.
- `raw_data` out 32: captured `dresp.data`; 0 for stores.
- `addr_err_load` / `addr_err_store` out 1: misaligned access (ADEL/ADES).
- `bad_vaddr` out 32: equals `in_args.addr`.

## Operation
- FSM `mem_state_t`: IDLE, REQ, WAIT, DONE, plus a `drop` flag.
- Alignment:
  - MSIZE2 needs `addr[0]`=0.
  - MSIZE4 needs `addr[1:0]`=0, except LWL/LWR/SWL/SWR, which never fault.
  - A misaligned access in IDLE raises the matching `addr_err_*` combinationally, issues no request, and keeps `stall`=0.
- Request build, latched on IDLE→REQ (k = `addr[1:0]`):
  - `dreq.addr` = `addr`, but `addr & ~3` for LWL/LWR/SWL/SWR.
  - `dreq.size` = `msize`.
  - Loads: `strobe` = 4'b0000.
  - SB: `strobe` = 1<<k, `data` = {4{rt[7:0]}}.
  - SH: `strobe` = 4'b0011 (k=0) or 4'b1100 (k=2), `data` = {2{rt[15:0]}}.
  - SW: `strobe` = 4'b1111, `data` = rt.
  - SWL: `strobe` bits [k:0] set, `data` = rt >> 8·(3−k).
  - SWR: `strobe` bits [3:k] set, `data` = rt << 8·k.
- IDLE: on `in_valid` & !`flush` & aligned, latch the request and go to REQ.
- REQ: `dreq.valid`=1 with fields stable until `addr_ok`.
  - `addr_ok` & `data_ok` in the same cycle: capture data, go to DONE.
  - `addr_ok` only: go to WAIT.
- WAIT: `dreq.valid`=0. On `data_ok`, capture `dresp.data` (stores capture 0) and go to DONE.
- DONE: `raw_valid`=1. On `advance` or `flush`, go to IDLE.
- `stall` = `in_valid` & !`flush` & aligned & (state ≠ DONE).
- Flush in IDLE/DONE: go to IDLE.
- Flush in REQ/WAIT: the bus transaction still completes (`valid` is never retracted before `addr_ok`). `drop` is set, and on `data_ok` the FSM goes to IDLE with no `raw_valid` pulse. `stall`=0 from the flush cycle; a new `in_valid` is not accepted until the FSM is back in IDLE.
- At most one outstanding transaction.

## Timing
- Reset values:
  - state IDLE, `drop`=0.
  - `dreq` all zero.
  - `raw_valid`=0, `raw_data`=0.
  - `stall`, `addr_err_*` follow inputs; 0 when `in_valid`=0.
- Reset mid-transaction: IDLE next cycle, `dreq.valid`=0. The bus shares the reset.
- `dreq` is registered. `dreq.valid` rises one cycle after `in_valid` is seen.
- Latency: with a zero-wait bus (`addr_ok` & `data_ok` on the first valid cycle), `raw_valid` is asserted 2 cycles after `in_valid`.
- Each wait cycle of the bus adds exactly 1 cycle.
- `raw_data` is stable from DONE entry until leaving DONE.

## Structure
- `mem_state_t` enum goes in the shared `mycpu` package. `dbus_req_t`, `dbus_resp_t`, `memory_args_t`, `msize_t` and `op_t` come from the existing shared headers.
- One combinational sub-module `memory_store_align` produces `strobe`/`data`/aligned `addr` from `op`, `msize` and `addr`. The FSM lives in the top.

## Test plan
- LW at 0x1000, zero-wait bus returning 0xDEADBEEF → `dreq` {valid, addr 0x1000, size MSIZE4, strobe 0}; `raw_valid` at cycle 2 with 0xDEADBEEF; `stall` high for 2 cycles.
- SB at 0x1003, rt=0x12345678 → strobe 4'b1000, data 0x78787878; `raw_data`=0.
- SWL at 0x2001, rt=0xAABBCCDD → addr 0x2000, strobe 4'b0011, data 0x0000AABB. SWR at 0x2001 → strobe 4'b1110, data 0xBBCCDD00.
- LH at 0x3001 → `addr_err_load`=1, `bad_vaddr`=0x3001, no `dreq.valid`, `stall`=0. SW at 0x3002 → `addr_err_store`=1.
- `addr_ok` delayed 3 cycles, then `data_ok` 2 cycles later → `dreq` fields unchanged throughout REQ; `valid` drops after `addr_ok`; `raw_valid` follows the `data_ok` cycle.
- `flush` asserted in WAIT → `stall` drops immediately; the FSM goes to IDLE after `data_ok` with no `raw_valid`. `reset` asserted in REQ → `dreq.valid`=0 next cycle.

Source files
------------

// File: rtl/memory_dreq_issue_pkg.sv
// Shared types for the memory-stage data-bus request path: bus structs,
// access descriptors and the request FSM state.
package memory_dreq_issue_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        Msize1 = 2'd0,
        Msize2 = 2'd1,
        Msize4 = 2'd2
    } msize_t;

    typedef enum logic [2:0] {
        OpNormal = 3'd0,
        OpLwl    = 3'd1,
        OpLwr    = 3'd2,
        OpSwl    = 3'd3,
        OpSwr    = 3'd4
    } op_t;

    typedef struct packed {
        word_t  addr;
        msize_t msize;
        logic   sig;
    } memory_args_t;

    typedef struct packed {
        logic       valid;
        word_t      addr;
        msize_t     size;
        logic [3:0] strobe;
        word_t      data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } mem_state_t;

    // Unaligned word ops address the containing word and never fault.
    function automatic logic is_partial_word(op_t op);
        return (op == OpLwl) || (op == OpLwr) || (op == OpSwl) || (op == OpSwr);
    endfunction

endpackage

// File: rtl/memory_dreq_issue_if.sv
// Data-bus request/response bundle between the memory stage and the bus.
interface memory_dreq_issue_if;
    import memory_dreq_issue_pkg::*;

    dbus_req_t  dreq;
    dbus_resp_t dresp;

    modport master (output dreq, input dresp);
    modport slave  (input dreq, output dresp);

endinterface

// File: rtl/memory_store_align.sv
// Combinational request builder: aligned address, byte strobe and lane-shifted
// store data for one memory-stage access.
module memory_store_align
    import memory_dreq_issue_pkg::*;
(
    input  logic       is_store,
    input  op_t        op,
    input  msize_t     msize,
    input  word_t      addr,
    input  word_t      store_data,
    output word_t      req_addr,
    output logic [3:0] strobe,
    output word_t      data
);

    logic [1:0] k;

    assign k        = addr[1:0];
    assign req_addr = is_partial_word(op) ? {addr[31:2], 2'b00} : addr;

    always_comb begin
        strobe = 4'b0000;
        data   = '0;
        if (is_store) begin
            if (op == OpSwl) begin
                // 8*(3-k) == {~k, 3'b000} for a 2-bit k
                data = store_data >> {~k, 3'b000};
                unique case (k)
                    2'd0: strobe = 4'b0001;
                    2'd1: strobe = 4'b0011;
                    2'd2: strobe = 4'b0111;
                    2'd3: strobe = 4'b1111;
                endcase
            end else if (op == OpSwr) begin
                data = store_data << {k, 3'b000};
                unique case (k)
                    2'd0: strobe = 4'b1111;
                    2'd1: strobe = 4'b1110;
                    2'd2: strobe = 4'b1100;
                    2'd3: strobe = 4'b1000;
                endcase
            end else begin
                unique case (msize)
                    Msize1: begin
                        strobe = 4'b0001 << k;
                        data   = {4{store_data[7:0]}};
                    end
                    Msize2: begin
                        strobe = k[1] ? 4'b1100 : 4'b0011;
                        data   = {2{store_data[15:0]}};
                    end
                    default: begin
                        strobe = 4'b1111;
                        data   = store_data;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/memory_dreq_issue.sv
// Memory-stage data-bus request controller: alignment check, registered
// request, valid/addr_ok/data_ok handshake and pipeline hold.
module memory_dreq_issue
    import memory_dreq_issue_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic                       in_is_store,
    input  op_t                        in_op,
    input  memory_args_t               in_args,
    input  word_t                      in_store_data,
    input  logic                       flush,
    input  logic                       advance,
    memory_dreq_issue_if.master        dbus,
    output logic                       stall,
    output logic                       raw_valid,
    output word_t                      raw_data,
    output logic                       addr_err_load,
    output logic                       addr_err_store,
    output word_t                      bad_vaddr
);

    mem_state_t state_q, state_d;
    logic       drop_q, drop_d;
    logic       is_store_q, is_store_d;
    dbus_req_t  dreq_q, dreq_d;
    word_t      raw_data_q, raw_data_d;

    word_t      al_addr;
    logic [3:0] al_strobe;
    word_t      al_data;
    logic       misaligned;
    logic       accept;
    logic       kill;
    logic       unused_sig;

    memory_store_align u_align (
        .is_store   (in_is_store),
        .op         (in_op),
        .msize      (in_args.msize),
        .addr       (in_args.addr),
        .store_data (in_store_data),
        .req_addr   (al_addr),
        .strobe     (al_strobe),
        .data       (al_data)
    );

    assign unused_sig = in_args.sig;

    assign misaligned = ((in_args.msize == Msize2) && in_args.addr[0]) ||
                        ((in_args.msize == Msize4) && (in_args.addr[1:0] != 2'b00) &&
                         !is_partial_word(in_op));
    assign accept     = in_valid && !flush && !misaligned;
    assign kill       = drop_q || flush;

    assign stall          = accept && (state_q != StDone);
    assign addr_err_load  = in_valid && !in_is_store && misaligned;
    assign addr_err_store = in_valid && in_is_store && misaligned;
    assign bad_vaddr      = in_args.addr;
    assign raw_valid      = (state_q == StDone);
    assign raw_data       = raw_data_q;
    assign dbus.dreq      = dreq_q;

    always_comb begin
        state_d    = state_q;
        drop_d     = drop_q;
        is_store_d = is_store_q;
        dreq_d     = dreq_q;
        raw_data_d = raw_data_q;
        unique case (state_q)
            StIdle: begin
                drop_d = 1'b0;
                if (accept) begin
                    dreq_d.valid  = 1'b1;
                    dreq_d.addr   = al_addr;
                    dreq_d.size   = in_args.msize;
                    dreq_d.strobe = al_strobe;
                    dreq_d.data   = al_data;
                    is_store_d    = in_is_store;
                    state_d       = StReq;
                end
            end
            StReq: begin
                // A flushed request stays on the bus until accepted; only its result is dropped.
                if (flush) drop_d = 1'b1;
                if (dbus.dresp.addr_ok) begin
                    dreq_d.valid = 1'b0;
                    if (dbus.dresp.data_ok) begin
                        if (kill) begin
                            state_d = StIdle;
                            drop_d  = 1'b0;
                        end else begin
                            state_d    = StDone;
                            raw_data_d = is_store_q ? '0 : dbus.dresp.data;
                        end
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (flush) drop_d = 1'b1;
                if (dbus.dresp.data_ok) begin
                    if (kill) begin
                        state_d = StIdle;
                        drop_d  = 1'b0;
                    end else begin
                        state_d    = StDone;
                        raw_data_d = is_store_q ? '0 : dbus.dresp.data;
                    end
                end
            end
            StDone: begin
                if (advance || flush) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            drop_q     <= 1'b0;
            is_store_q <= 1'b0;
            dreq_q     <= '0;
            raw_data_q <= '0;
        end else begin
            state_q    <= state_d;
            drop_q     <= drop_d;
            is_store_q <= is_store_d;
            dreq_q     <= dreq_d;
            raw_data_q <= raw_data_d;
        end
    end

endmodule

// File: tb/tb_memory_dreq_issue.sv
// Self-checking bench for memory_dreq_issue: directed scenarios plus randomized
// accesses checked against a byte-lane/cycle-count reference model.
module tb_memory_dreq_issue;
    import memory_dreq_issue_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_is_store;
    op_t          in_op;
    memory_args_t in_args;
    word_t        in_store_data;
    logic         flush;
    logic         advance;
    logic         stall;
    logic         raw_valid;
    word_t        raw_data;
    logic         addr_err_load;
    logic         addr_err_store;
    word_t        bad_vaddr;

    int n_cmp  = 0;
    int n_fail = 0;

    memory_dreq_issue_if dbus ();

    memory_dreq_issue dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_is_store    (in_is_store),
        .in_op          (in_op),
        .in_args        (in_args),
        .in_store_data  (in_store_data),
        .flush          (flush),
        .advance        (advance),
        .dbus           (dbus),
        .stall          (stall),
        .raw_valid      (raw_valid),
        .raw_data       (raw_data),
        .addr_err_load  (addr_err_load),
        .addr_err_store (addr_err_store),
        .bad_vaddr      (bad_vaddr)
    );

    always #5 clk = ~clk;

    // Reference request: each memory byte lane decided on its own from the access rules.
    function automatic void model_req(input logic st, input op_t op, input msize_t ms,
                                      input word_t a, input word_t rt, output word_t ea,
                                      output logic [3:0] es, output word_t ed);
        int k;
        k  = int'(a[1:0]);
        ea = (op != OpNormal) ? (a / 4) * 4 : a;
        es = 4'b0000;
        ed = '0;
        if (st) begin
            for (int j = 0; j < 4; j++) begin
                int src;
                logic en;
                src = -1;
                en  = 1'b0;
                if (op == OpSwl) begin
                    en = (j <= k);
                    if (en) src = j + 3 - k;
                end else if (op == OpSwr) begin
                    en = (j >= k);
                    if (en) src = j - k;
                end else if (ms == Msize1) begin
                    en  = (j == k);
                    src = 0;
                end else if (ms == Msize2) begin
                    en  = ((j / 2) == (k / 2));
                    src = j % 2;
                end else begin
                    en  = 1'b1;
                    src = j;
                end
                es[j] = en;
                if (src >= 0) ed[8*j +: 8] = rt[8*src +: 8];
            end
        end
    endfunction

    task automatic idle_inputs();
        in_valid            = 1'b0;
        in_is_store         = 1'b0;
        in_op               = OpNormal;
        in_args             = '0;
        in_store_data       = '0;
        flush               = 1'b0;
        advance             = 1'b0;
        dbus.dresp.addr_ok  = 1'b0;
        dbus.dresp.data_ok  = 1'b0;
        dbus.dresp.data     = '0;
    endtask

    task automatic drive_access(input logic st, input op_t op, input msize_t ms,
                                input word_t a, input word_t rt);
        in_valid      = 1'b1;
        in_is_store   = st;
        in_op         = op;
        in_args.addr  = a;
        in_args.msize = ms;
        in_args.sig   = 1'($urandom_range(0, 1));
        in_store_data = rt;
    endtask

    // One complete access: aw cycles before addr_ok, dw more before data_ok.
    task automatic run_txn(input logic st, input op_t op, input msize_t ms, input word_t a,
                           input word_t rt, input int aw, input int dw, input word_t resp);
        word_t      ea;
        logic [3:0] es;
        word_t      ed;
        int         done_c;
        logic       exp_v;
        model_req(st, op, ms, a, rt, ea, es, ed);
        done_c = 2 + aw + dw;
        for (int c = 0; c <= done_c + 1; c++) begin
            if (c <= done_c) drive_access(st, op, ms, a, rt);
            else in_valid = 1'b0;
            advance            = (c == done_c);
            dbus.dresp.addr_ok = (c == 1 + aw);
            dbus.dresp.data_ok = (c == 1 + aw + dw);
            dbus.dresp.data    = dbus.dresp.data_ok ? resp : $urandom;
            @(negedge clk);
            n_cmp++;
            if (stall !== (c < done_c)) begin
                n_fail++;
                $display("FAIL txn_stall @%h c=%0d: got %b want %b", a, c, stall, c < done_c);
            end
            exp_v = (c >= 1) && (c <= 1 + aw);
            n_cmp++;
            if (dbus.dreq.valid !== exp_v) begin
                n_fail++;
                $display("FAIL txn_valid @%h c=%0d: got %b want %b", a, c, dbus.dreq.valid, exp_v);
            end
            if (exp_v) begin
                n_cmp++;
                if (dbus.dreq.addr !== ea || dbus.dreq.size !== ms || dbus.dreq.strobe !== es ||
                    (st && dbus.dreq.data !== ed)) begin
                    n_fail++;
                    $display("FAIL txn_req c=%0d: got a=%h s=%0d b=%b d=%h want a=%h s=%0d b=%b d=%h",
                             c, dbus.dreq.addr, dbus.dreq.size, dbus.dreq.strobe, dbus.dreq.data,
                             ea, ms, es, ed);
                end
            end
            n_cmp++;
            if (raw_valid !== (c == done_c)) begin
                n_fail++;
                $display("FAIL txn_raw_valid @%h c=%0d: got %b want %b", a, c, raw_valid,
                         c == done_c);
            end
            if (c == done_c) begin
                n_cmp++;
                if (raw_data !== (st ? 32'h0 : resp)) begin
                    n_fail++;
                    $display("FAIL txn_raw_data @%h: got %h want %h", a, raw_data,
                             st ? 32'h0 : resp);
                end
            end
            if (c == 0) begin
                n_cmp++;
                if (addr_err_load !== 1'b0 || addr_err_store !== 1'b0) begin
                    n_fail++;
                    $display("FAIL txn_no_adderr @%h: got %b%b want 00", a, addr_err_load,
                             addr_err_store);
                end
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (dbus.dreq !== '0 || raw_valid !== 1'b0 || raw_data !== '0 || stall !== 1'b0 ||
            addr_err_load !== 1'b0 || addr_err_store !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got dreq=%h rv=%b rd=%h st=%b err=%b%b want all zero",
                     dbus.dreq, raw_valid, raw_data, stall, addr_err_load, addr_err_store);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        run_txn(1'b0, OpNormal, Msize4, 32'h0000_1000, 32'h0, 0, 0, 32'hDEAD_BEEF);
        run_txn(1'b1, OpNormal, Msize1, 32'h0000_1003, 32'h1234_5678, 0, 0, 32'hFFFF_FFFF);
        run_txn(1'b1, OpSwl, Msize4, 32'h0000_2001, 32'hAABB_CCDD, 0, 1, 32'h0);
        run_txn(1'b1, OpSwr, Msize4, 32'h0000_2001, 32'hAABB_CCDD, 1, 0, 32'h0);
        run_txn(1'b0, OpNormal, Msize4, 32'h0000_1004, 32'h0, 3, 2, 32'hCAFE_F00D);
    endtask

    task automatic test_misaligned();
        logic  st[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        msize_t ms[4] = '{Msize2, Msize4, Msize4, Msize2};
        word_t a[4]   = '{32'h0000_3001, 32'h0000_3002, 32'h0000_7003, 32'h0000_8005};
        for (int i = 0; i < 4; i++) begin
            drive_access(st[i], OpNormal, ms[i], a[i], $urandom);
            @(negedge clk);
            n_cmp++;
            if (addr_err_load !== !st[i] || addr_err_store !== st[i] || bad_vaddr !== a[i] ||
                stall !== 1'b0) begin
                n_fail++;
                $display("FAIL misaligned_%0d: got el=%b es=%b bv=%h st=%b want el=%b es=%b bv=%h st=0",
                         i, addr_err_load, addr_err_store, bad_vaddr, stall, !st[i], st[i], a[i]);
            end
            @(posedge clk);
            #1;
            idle_inputs();
            @(negedge clk);
            n_cmp++;
            if (dbus.dreq.valid !== 1'b0) begin
                n_fail++;
                $display("FAIL misaligned_noreq_%0d: got %b want 0", i, dbus.dreq.valid);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Flush while waiting for data, with the next access already presented during the drain.
    task automatic test_flush_in_wait();
        logic exp_stall, exp_v, exp_rv;
        for (int c = 0; c <= 8; c++) begin
            idle_inputs();
            if (c <= 2) drive_access(1'b0, OpNormal, Msize4, 32'h0000_4000, 32'h0);
            else if (c <= 7) drive_access(1'b0, OpNormal, Msize4, 32'h0000_5000, 32'h0);
            flush              = (c == 2);
            advance            = (c == 7);
            dbus.dresp.addr_ok = (c == 1) || (c == 6);
            dbus.dresp.data_ok = (c == 4) || (c == 6);
            dbus.dresp.data    = (c == 6) ? 32'h5555_AAAA : $urandom;
            @(negedge clk);
            exp_stall = (c <= 1) || (c >= 3 && c <= 6);
            exp_v     = (c == 1) || (c == 6);
            exp_rv    = (c == 7);
            n_cmp++;
            if (stall !== exp_stall || dbus.dreq.valid !== exp_v || raw_valid !== exp_rv) begin
                n_fail++;
                $display("FAIL flush_wait c=%0d: got st=%b v=%b rv=%b want st=%b v=%b rv=%b",
                         c, stall, dbus.dreq.valid, raw_valid, exp_stall, exp_v, exp_rv);
            end
            if (exp_v) begin
                n_cmp++;
                if (dbus.dreq.addr !== ((c == 1) ? 32'h0000_4000 : 32'h0000_5000)) begin
                    n_fail++;
                    $display("FAIL flush_wait_addr c=%0d: got %h", c, dbus.dreq.addr);
                end
            end
            if (c == 7) begin
                n_cmp++;
                if (raw_data !== 32'h5555_AAAA) begin
                    n_fail++;
                    $display("FAIL flush_wait_data: got %h want 5555aaaa", raw_data);
                end
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();
    endtask

    task automatic test_reset_in_req();
        for (int c = 0; c <= 3; c++) begin
            idle_inputs();
            if (c <= 2) drive_access(1'b1, OpNormal, Msize4, 32'h0000_6000, 32'h0BAD_F00D);
            reset = (c == 2);
            @(negedge clk);
            if (c >= 1) begin
                n_cmp++;
                if (dbus.dreq.valid !== (c <= 2) || raw_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_in_req c=%0d: got v=%b rv=%b want v=%b rv=0",
                             c, dbus.dreq.valid, raw_valid, c <= 2);
                end
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        idle_inputs();
        run_txn(1'b0, OpNormal, Msize2, 32'h0000_6002, 32'h0, 0, 0, 32'h1357_9BDF);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int     kind;
            logic   st;
            op_t    op;
            msize_t ms;
            word_t  a;
            kind = $urandom_range(0, 4);
            st   = 1'($urandom_range(0, 1));
            a    = $urandom;
            op   = OpNormal;
            unique case (kind)
                0: ms = Msize1;
                1: begin ms = Msize2; a[0] = 1'b0; end
                2: begin ms = Msize4; a[1:0] = 2'b00; end
                3: begin ms = Msize4; op = st ? OpSwl : OpLwl; end
                default: begin ms = Msize4; op = st ? OpSwr : OpLwr; end
            endcase
            run_txn(st, op, ms, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_directed();
        test_misaligned();
        test_flush_in_wait();
        test_reset_in_req();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
